// File: rtl/sum_method_responder.sv
// Method-call responder for calc(n): returns the wrapping sum 1+2+...+n,
// accumulating one term per clock, with a sticky overflow flag per call.
module sum_method_responder #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             calc_req,
   input  logic [WIDTH-1:0] calc_n,
   output logic             calc_busy,
   output logic [WIDTH-1:0] calc_return,
   output logic             calc_ovf
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } state_t;

   localparam logic [WIDTH:0] I_ONE = {{WIDTH{1'b0}}, 1'b1};

   state_t           state_reg, state_next;
   logic             req_d_reg;
   logic [WIDTH-1:0] n_reg, n_next;
   logic [WIDTH-1:0] acc_reg, acc_next;
   logic [WIDTH:0]   i_reg, i_next;       // one bit wider so n = 2^WIDTH-1 terminates
   logic             ovf_reg, ovf_next;
   logic             busy_reg, busy_next;
   logic [WIDTH-1:0] ret_reg, ret_next;
   logic             ovf_out_reg, ovf_out_next;
   logic             start;
   logic [WIDTH:0]   sum;

   assign start = calc_req & ~req_d_reg & (state_reg == IDLE);
   // i never exceeds n while adding, so the carry out lands in sum[WIDTH]
   assign sum   = {1'b0, acc_reg} + i_reg;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg   <= IDLE;
         req_d_reg   <= 1'b0;
         n_reg       <= '0;
         acc_reg     <= '0;
         i_reg       <= '0;
         ovf_reg     <= 1'b0;
         busy_reg    <= 1'b0;
         ret_reg     <= '0;
         ovf_out_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         req_d_reg   <= calc_req;
         n_reg       <= n_next;
         acc_reg     <= acc_next;
         i_reg       <= i_next;
         ovf_reg     <= ovf_next;
         busy_reg    <= busy_next;
         ret_reg     <= ret_next;
         ovf_out_reg <= ovf_out_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      n_next       = n_reg;
      acc_next     = acc_reg;
      i_next       = i_reg;
      ovf_next     = ovf_reg;
      busy_next    = busy_reg;
      ret_next     = ret_reg;
      ovf_out_next = ovf_out_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               n_next     = calc_n;
               acc_next   = '0;
               i_next     = I_ONE;
               ovf_next   = 1'b0;
               busy_next  = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            if (i_reg > {1'b0, n_reg}) begin
               state_next = FINISH;
            end else begin
               acc_next = sum[WIDTH-1:0];
               ovf_next = ovf_reg | sum[WIDTH];
               i_next   = i_reg + I_ONE;
            end
         end
         FINISH: begin
            // result, flag and busy all update on the same edge
            ret_next     = acc_reg;
            ovf_out_next = ovf_reg;
            busy_next    = 1'b0;
            state_next   = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign calc_busy   = busy_reg;
   assign calc_return = ret_reg;
   assign calc_ovf    = ovf_out_reg;

endmodule

// File: tb/tb_sum_method_responder.sv
// Directed known-answer bench for sum_method_responder; a 16-bit instance
// keeps the overflow and wrap cases to a few hundred cycles each.
module tb_sum_method_responder;

   localparam int W = 16;

   logic         clk;
   logic         reset;
   logic         calc_req;
   logic [W-1:0] calc_n;
   logic         calc_busy;
   logic [W-1:0] calc_return;
   logic         calc_ovf;

   int vectors;
   int miscompares;
   int len;
   int cnt;

   sum_method_responder #(.WIDTH(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .calc_req    (calc_req),
      .calc_n      (calc_n),
      .calc_busy   (calc_busy),
      .calc_return (calc_return),
      .calc_ovf    (calc_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Counts busy cycles of one call; optionally drops calc_req once busy is seen.
   task automatic wait_done(input bit drop_req, output int busy_len);
      bit seen;
      seen     = 1'b0;
      busy_len = 0;
      for (int c = 0; c < 3000; c++) begin
         tick();
         if (calc_busy) begin
            busy_len++;
            seen = 1'b1;
            if (drop_req) calc_req = 1'b0;
         end else if (seen) begin
            break;
         end
      end
   endtask

   task automatic count_busy(input int cycles, output int busy_cnt);
      busy_cnt = 0;
      for (int c = 0; c < cycles; c++) begin
         tick();
         if (calc_busy) busy_cnt++;
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b0;
      calc_req    = 1'b0;
      calc_n      = '0;

      // Reset and idle
      repeat (6) tick();
      check("reset_busy", 32'(calc_busy), 32'd0);
      reset = 1'b1;
      tick();
      check("post_reset_busy", 32'(calc_busy), 32'd0);
      check("post_reset_return", 32'(calc_return), 32'd0);
      check("post_reset_ovf", 32'(calc_ovf), 32'd0);
      count_busy(20, cnt);
      check("idle_no_busy", 32'(cnt), 32'd0);

      // n=10, request held high afterwards
      calc_n   = 16'd10;
      calc_req = 1'b1;
      wait_done(1'b0, len);
      check("n10_len", 32'(len), 32'd12);
      check("n10_return", 32'(calc_return), 32'd55);
      check("n10_ovf", 32'(calc_ovf), 32'd0);
      count_busy(50, cnt);
      check("n10_no_retrigger", 32'(cnt), 32'd0);

      // n=0 pulse
      calc_req = 1'b0;
      tick();
      calc_n   = 16'd0;
      calc_req = 1'b1;
      wait_done(1'b1, len);
      check("n0_len", 32'(len), 32'd2);
      check("n0_return", 32'(calc_return), 32'd0);
      check("n0_ovf", 32'(calc_ovf), 32'd0);

      // n=1000 wraps 16 bits: 500500 mod 65536 = 41748
      calc_n   = 16'd1000;
      calc_req = 1'b1;
      wait_done(1'b1, len);
      check("n1000_len", 32'(len), 32'd1002);
      check("n1000_return", 32'(calc_return), 32'd41748);
      check("n1000_ovf", 32'(calc_ovf), 32'd1);

      // n=3 clears the sticky flag
      calc_n   = 16'd3;
      calc_req = 1'b1;
      wait_done(1'b1, len);
      check("n3_return", 32'(calc_return), 32'd6);
      check("n3_ovf", 32'(calc_ovf), 32'd0);

      // Overflow boundary: 361 -> 65341 fits, 362 -> 65703 wraps to 167
      calc_n   = 16'd361;
      calc_req = 1'b1;
      wait_done(1'b1, len);
      check("n361_return", 32'(calc_return), 32'd65341);
      check("n361_ovf", 32'(calc_ovf), 32'd0);
      calc_n   = 16'd362;
      calc_req = 1'b1;
      wait_done(1'b1, len);
      check("n362_return", 32'(calc_return), 32'd167);
      check("n362_ovf", 32'(calc_ovf), 32'd1);

      // n=300 with argument change and second request edge mid-call
      calc_n   = 16'd300;
      calc_req = 1'b1;
      len      = 0;
      for (int c = 0; c < 1000; c++) begin
         tick();
         if (c == 20) begin
            calc_n   = 16'd5;
            calc_req = 1'b0;
         end
         if (c == 22) calc_req = 1'b1;
         if (calc_busy) len++;
         else if (len > 0) break;
      end
      check("midcall_len", 32'(len), 32'd302);
      check("midcall_return", 32'(calc_return), 32'd45150);
      check("midcall_ovf", 32'(calc_ovf), 32'd0);
      count_busy(30, cnt);
      check("midcall_no_second", 32'(cnt), 32'd0);

      // Reset mid-call, request held across release
      calc_req = 1'b0;
      tick();
      calc_n   = 16'd50;
      calc_req = 1'b1;
      cnt      = 0;
      for (int c = 0; c < 40 && cnt < 10; c++) begin
         tick();
         if (calc_busy) cnt++;
      end
      check("pre_reset_busy", 32'(calc_busy), 32'd1);
      reset = 1'b0;
      tick();
      check("abort_busy", 32'(calc_busy), 32'd0);
      check("abort_return", 32'(calc_return), 32'd0);
      reset = 1'b1;
      wait_done(1'b0, len);
      check("restart_len", 32'(len), 32'd52);
      check("restart_return", 32'(calc_return), 32'd1275);
      check("restart_ovf", 32'(calc_ovf), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
